// File: rtl/circular_shift_pkg.sv
// Shared types and constants for the circular shifter/unshifter pair on the systolic path.
// Word 32 of each vector carries the row checksum.
package circular_shift_pkg;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 33;
  localparam int VEC_W   = WORD_W * N_WORDS;
  localparam int STAGES  = 6;
  localparam int STEP_W  = 6;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // A 6-bit step never reaches 66, so one conditional subtract gives mod 33.
  function automatic logic [STEP_W-1:0] reduce_step(input logic [STEP_W-1:0] step);
    if (step >= STEP_W'(N_WORDS)) begin
      return step - STEP_W'(N_WORDS);
    end
    return step;
  endfunction

  // res[i] = vec[(i + src_off) mod 33]; src_off is a constant at every call site.
  function automatic logic [VEC_W-1:0] rotate_words(input logic [VEC_W-1:0] vec,
                                                    input int src_off);
    logic [VEC_W-1:0] res;
    res = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      res[i*WORD_W +: WORD_W] = vec[((i + src_off) % N_WORDS)*WORD_W +: WORD_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/word_checksum.sv
// Row checksum check: sum of words 0..31 mod 2^32 compared against word 32.
// Only instantiated when CHECKSUM_CHECK_EN is defined.
module word_checksum
  import circular_shift_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             err
);

  logic [WORD_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int j = 0; j < N_WORDS - 1; j++) begin
      sum = sum + vec[j*WORD_W +: WORD_W];
    end
    err = (sum != vec[(N_WORDS-1)*WORD_W +: WORD_W]);
  end

endmodule

// File: rtl/circular_unshifter.sv
// Rotates a 33-word vector back to natural order with a 6-stage iterative log-shift.
// Optional feature macro CHECKSUM_CHECK_EN adds the CHK state and the checksum_err port.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a vector
//   ROT   | one log-shift stage per cycle, stage_q = 0..5
//   CHK   | row checksum compared (CHECKSUM_CHECK_EN only)
//   DONE  | out_valid high, held until out_ready
module circular_unshifter
  import circular_shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VEC_W-1:0]   dataBr_Cf_in,
  input  logic               shift_direction,
  input  logic [STEP_W-1:0]  step_size,
  input  logic               direct_connection,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [VEC_W-1:0]   dataBr_Cf_out,
  output logic               out_valid,
  input  logic               out_ready
`ifdef CHECKSUM_CHECK_EN
  ,
  output logic               checksum_err
`endif
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  stage_q, stage_d;
  logic [VEC_W-1:0]  work_q;
  logic [VEC_W-1:0]  stage_vec;
  logic [STEP_W-1:0] step_q;
  logic              dir_q;
  logic              bypass_q;
  logic              accept;

  logic [VEC_W-1:0]  undo_right [STAGES];
  logic [VEC_W-1:0]  undo_down  [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign undo_right[k] = rotate_words(work_q, 1 << k);
    assign undo_down[k]  = rotate_words(work_q, N_WORDS - (1 << k));
  end

  always_comb begin
    stage_vec = work_q;
    for (int k = 0; k < STAGES; k++) begin
      if (!bypass_q && (stage_q == CNT_W'(k)) && step_q[k]) begin
        stage_vec = (dir_q == DIR_RIGHT) ? undo_right[k] : undo_down[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ROT;
          // Bypass spends a single non-rotating pass so out_valid lands one edge later.
          stage_d = direct_connection ? CNT_W'(STAGES - 1) : '0;
        end
      end
      ROT: begin
        stage_d = stage_q + 1'b1;
        if (stage_q == CNT_W'(STAGES - 1)) begin
          stage_d = '0;
`ifdef CHECKSUM_CHECK_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end
      end
      CHK: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        stage_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= '0;
      step_q   <= '0;
      dir_q    <= DIR_RIGHT;
      bypass_q <= 1'b0;
    end else if (accept) begin
      work_q   <= dataBr_Cf_in;
      step_q   <= reduce_step(step_size);
      dir_q    <= shift_direction;
      bypass_q <= direct_connection;
    end else if (state_q == ROT) begin
      work_q   <= stage_vec;
    end
  end

`ifdef CHECKSUM_CHECK_EN
  logic sum_err;

  word_checksum u_word_checksum (
    .vec (work_q),
    .err (sum_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_err <= 1'b0;
    end else if (accept) begin
      checksum_err <= 1'b0;
    end else if (state_q == CHK) begin
      checksum_err <= sum_err;
    end
  end
`endif

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign dataBr_Cf_out = work_q;

endmodule
